// File: rtl/dct8_transpose_buf_if.sv
// dct8_transpose_buf_if: row-in / column-out handshake bundle of the transpose buffer
interface dct8_transpose_buf_if #(
  parameter int DATA_W = 16
);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
  modport slave (
    input in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    output in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
  );
  modport master (
    output in_valid, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    input in_ready, out_valid, out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface

// File: rtl/dct8_transpose_buf.sv
// dct8_transpose_buf: ping-pong 8x8 transpose buffer, rows in and columns out
module dct8_transpose_buf #(
  parameter int DATA_W = 16,
  parameter int N = 8
) (
  input logic clk,
  input logic rst,
  dct8_transpose_buf_if.slave bus
);
  logic [DATA_W-1:0] r_mem [2][N][N];
  logic r_wr_sel, r_rd_sel;
  logic [2:0] r_wr_row, r_rd_col;
  logic [1:0] r_full;
  logic [DATA_W-1:0] w_in [N];
  logic [DATA_W-1:0] w_out [N];
  logic w_in_fire, w_out_fire, w_wr_last, w_rd_last;
  logic [1:0] w_set, w_clr;
  assign w_in[0] = bus.in0;
  assign w_in[1] = bus.in1;
  assign w_in[2] = bus.in2;
  assign w_in[3] = bus.in3;
  assign w_in[4] = bus.in4;
  assign w_in[5] = bus.in5;
  assign w_in[6] = bus.in6;
  assign w_in[7] = bus.in7;
  assign bus.in_ready = !r_full[r_wr_sel];
  assign bus.out_valid = r_full[r_rd_sel];
  assign w_in_fire = bus.in_valid && bus.in_ready;
  assign w_out_fire = bus.out_valid && bus.out_ready;
  assign w_wr_last = w_in_fire && r_wr_row == 3'd7;
  assign w_rd_last = w_out_fire && r_rd_col == 3'd7;
  assign w_set = w_wr_last ? 2'b01 << r_wr_sel : 2'b00;
  assign w_clr = w_rd_last ? 2'b01 << r_rd_sel : 2'b00;
  always_comb begin
    for (int r = 0; r < N; r++) w_out[r] = bus.out_valid ? r_mem[r_rd_sel][r][r_rd_col] : '0;
  end
  assign bus.out0 = w_out[0];
  assign bus.out1 = w_out[1];
  assign bus.out2 = w_out[2];
  assign bus.out3 = w_out[3];
  assign bus.out4 = w_out[4];
  assign bus.out5 = w_out[5];
  assign bus.out6 = w_out[6];
  assign bus.out7 = w_out[7];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_wr_row <= 3'd0;
      r_rd_sel <= 1'b0;
      r_rd_col <= 3'd0;
      r_full <= 2'b00;
    end else begin
      if (w_in_fire) r_wr_row <= r_wr_row + 3'd1;
      if (w_wr_last) r_wr_sel <= !r_wr_sel;
      if (w_out_fire) r_rd_col <= r_rd_col + 3'd1;
      if (w_rd_last) r_rd_sel <= !r_rd_sel;
      r_full <= (r_full | w_set) & ~w_clr;
    end
  end
  always_ff @(posedge clk) begin
    if (w_in_fire) for (int k = 0; k < N; k++) r_mem[r_wr_sel][r_wr_row][k] <= w_in[k];
  end
endmodule
